// File: rtl/deser_pkg.sv
// Shared defaults and state encoding for the serial-to-parallel deserializer.
package deser_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_MOD_W  = $clog2(DEF_DATA_W);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } deser_state_t;

endpackage

// File: rtl/deserializer.sv
// Collects MSB-first serial bits into a left-aligned word; a word closes on the
// DATA_W-th bit or on an early ser_last_i, and is presented for one cycle.
module deserializer
    import deser_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned MOD_W  = DEF_MOD_W
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              ser_data_i,
    input  logic              ser_data_val_i,
    input  logic              ser_last_i,
    output logic [DATA_W-1:0] deser_data_o,
    output logic [MOD_W-1:0]  deser_data_mod_o,
    output logic              deser_data_val_o,
    output logic              busy_o
);

    localparam logic [DATA_W-1:0] MSB_ONE = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [MOD_W-1:0]  LAST_IDX = MOD_W'(DATA_W - 1);

    deser_state_t      r_state;
    logic [MOD_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_data;
    logic [MOD_W-1:0]  r_mod;
    logic              r_data_val;
    logic              r_busy;

    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              w_full;
    logic              w_done;

    // A word starting in IDLE discards whatever the previous word left behind.
    assign w_mask      = MSB_ONE >> r_cnt;
    assign w_shift_nxt = ((r_state == IDLE) ? '0 : r_shift) | (ser_data_i ? w_mask : '0);
    assign w_full      = (r_cnt == LAST_IDX);
    assign w_done      = w_full | ser_last_i;

    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_mod      <= '0;
            r_data_val <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_data_val <= 1'b0;
            if (ser_data_val_i) begin
                r_shift <= w_shift_nxt;
                if (w_done) begin
                    r_data     <= w_shift_nxt;
                    r_mod      <= w_full ? '0 : MOD_W'(r_cnt + 1'b1);
                    r_data_val <= 1'b1;
                    r_cnt      <= '0;
                    r_state    <= IDLE;
                    r_busy     <= 1'b0;
                end else begin
                    r_cnt      <= MOD_W'(r_cnt + 1'b1);
                    r_state    <= COLLECT;
                    r_busy     <= 1'b1;
                end
            end
        end
    end

    assign deser_data_o     = r_data;
    assign deser_data_mod_o = r_mod;
    assign deser_data_val_o = r_data_val;
    assign busy_o           = r_busy;

endmodule
